// File: rtl/aurora_bist_checker.sv
// aurora_bist_checker
//   Receive-side PRBS BIST checker for the Aurora AXIS MAC (PHY RX clock
//   domain, no backpressure). It self-synchronises to the 64-bit-per-word
//   PRBS (x^64+x^63+x^61+x^60+1, one step per valid word) and reports lock
//   status plus compared-word, word-error and lock-loss counts.
//
// Ports
//   clk          phy user clock, all logic on posedge
//   rst          asynchronous active-high reset
//   en           checker enable; low forces IDLE and freezes the counters
//   i_tdata      PHY RX data word (64 bits)
//   i_tvalid     PHY RX word valid; every valid word is consumed
//   locked       checker locked to the PRBS
//   samps        words compared while locked (saturating, CNT_W bits)
//   errors       mismatching words while locked (saturating, CNT_W bits)
//   lock_losses  number of LOCKED->SEEK transitions (saturating, 16 bits)
module aurora_bist_checker #(
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [63:0]       i_tdata,
  input  logic              i_tvalid,
  output logic              locked,
  output logic [CNT_W-1:0]  samps,
  output logic [CNT_W-1:0]  errors,
  output logic [15:0]       lock_losses
);

  localparam int DATA_W  = 64;
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int RUN_W   = $clog2(UNLOCK_ERRS + 1);

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   pred;
  logic [MATCH_W-1:0]  match_cnt;
  logic [RUN_W-1:0]    err_run;

  logic word_zero;
  logic word_hit;

  function automatic logic [DATA_W-1:0] prbs_next(input logic [DATA_W-1:0] w);
    return {w[62:0], w[63] ^ w[62] ^ w[60] ^ w[59]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc_16(input logic [15:0] c);
    return (&c) ? c : c + 16'd1;
  endfunction

  assign word_zero = (i_tdata == '0);
  assign word_hit  = (i_tdata == pred);

  // Single registered stage: every output reflects the word sampled on the
  // previous edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      locked      <= 1'b0;
      samps       <= '0;
      errors      <= '0;
      lock_losses <= '0;
      pred        <= '0;
      match_cnt   <= '0;
      err_run     <= '0;
    end else if (!en) begin
      // Disabling wins over any word arriving in the same cycle.
      state  <= IDLE;
      locked <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          locked      <= 1'b0;
          samps       <= '0;
          errors      <= '0;
          lock_losses <= '0;
          match_cnt   <= '0;
          err_run     <= '0;
          state       <= SEEK;
        end

        SEEK: begin
          // The all-zero word can never seed the generator polynomial.
          if (i_tvalid && !word_zero) begin
            pred      <= prbs_next(i_tdata);
            match_cnt <= '0;
            state     <= ACQUIRE;
          end
        end

        ACQUIRE: begin
          if (i_tvalid) begin
            if (word_hit) begin
              pred      <= prbs_next(i_tdata);
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == MATCH_LAST) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                err_run <= '0;
              end
            end else if (!word_zero) begin
              pred      <= prbs_next(i_tdata);
              match_cnt <= '0;
            end else begin
              state <= SEEK;
            end
          end
        end

        LOCKED: begin
          if (i_tvalid) begin
            samps <= sat_inc_cnt(samps);
            // Flywheel: prediction never follows received data once locked,
            // so isolated bit errors do not disturb later comparisons.
            pred  <= prbs_next(pred);
            if (word_hit) begin
              err_run <= '0;
            end else begin
              errors <= sat_inc_cnt(errors);
              if (err_run == RUN_LAST) begin
                state       <= SEEK;
                locked      <= 1'b0;
                lock_losses <= sat_inc_16(lock_losses);
                err_run     <= '0;
              end else begin
                err_run <= err_run + 1'b1;
              end
            end
          end
        end

        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_bist_checker.sv
// tb_aurora_bist_checker
//   Scoreboard bench for aurora_bist_checker. A second instance with 4-bit
//   counters shares the stimulus so counter saturation is exercised.
module tb_aurora_bist_checker;

  localparam int LOCK_COUNT  = 8;
  localparam int UNLOCK_ERRS = 4;
  localparam int CNT_W       = 48;
  localparam int SAT_W       = 4;
  localparam longint unsigned SAT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [63:0]       i_tdata;
  logic              i_tvalid;
  logic              locked, locked_s;
  logic [CNT_W-1:0]  samps, errors;
  logic [SAT_W-1:0]  samps_s, errors_s;
  logic [15:0]       lock_losses, lock_losses_s;

  always #5 clk = ~clk;

  aurora_bist_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .i_tdata(i_tdata), .i_tvalid(i_tvalid),
    .locked(locked), .samps(samps), .errors(errors), .lock_losses(lock_losses));

  aurora_bist_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .i_tdata(i_tdata), .i_tvalid(i_tvalid),
    .locked(locked_s), .samps(samps_s), .errors(errors_s), .lock_losses(lock_losses_s));

  typedef struct {
    bit              lk;
    longint unsigned sm;
    longint unsigned er;
    int              ll;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state
  bit              m_act, m_seed, m_lock;
  int              m_match, m_bad, m_ll;
  logic [63:0]     m_pred;
  longint unsigned m_samps, m_errs;

  // Stimulus PRBS generator
  logic [63:0] g;

  function automatic logic [63:0] prbs(input logic [63:0] w);
    logic [63:0] r;
    r = w << 1;
    r[0] = w[63] ^ w[62] ^ w[60] ^ w[59];
    return r;
  endfunction

  function automatic void model_reset();
    m_act = 0; m_seed = 0; m_lock = 0; m_match = 0; m_bad = 0; m_ll = 0;
    m_pred = '0; m_samps = 0; m_errs = 0;
  endfunction

  function automatic void model(input bit e, input bit v, input logic [63:0] d);
    if (!e) begin
      m_act = 0; m_lock = 0;
      return;
    end
    if (!m_act) begin
      m_act = 1; m_seed = 0; m_lock = 0; m_match = 0; m_bad = 0;
      m_samps = 0; m_errs = 0; m_ll = 0;
      return;
    end
    if (!v) return;
    if (m_lock) begin
      m_samps++;
      if (d != m_pred) begin m_errs++; m_bad++; end
      else m_bad = 0;
      m_pred = prbs(m_pred);
      if (m_bad == UNLOCK_ERRS) begin
        m_lock = 0; m_seed = 0; m_bad = 0;
        if (m_ll < 65535) m_ll++;
      end
    end else if (!m_seed) begin
      if (d != 0) begin m_seed = 1; m_pred = prbs(d); m_match = 0; end
    end else if (d == m_pred) begin
      m_pred = prbs(d);
      m_match++;
      if (m_match == LOCK_COUNT) m_lock = 1;
    end else if (d != 0) begin
      m_pred = prbs(d); m_match = 0;
    end else begin
      m_seed = 0;
    end
  endfunction

  function automatic longint unsigned cap(input longint unsigned x);
    return (x > SAT_MAX) ? SAT_MAX : x;
  endfunction

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock of stimulus; expected post-edge outputs go to the scoreboard.
  task automatic step(input bit e, input bit v, input logic [63:0] d);
    exp_t x;
    @(negedge clk);
    en = e; i_tvalid = v; i_tdata = d;
    model(e, v, d);
    x.lk = m_lock; x.sm = m_samps; x.er = m_errs; x.ll = m_ll;
    sb_q.push_back(x);
  endtask

  task automatic good();
    step(1, 1, g);
    g = prbs(g);
  endtask

  task automatic bad(input int b);
    step(1, 1, g ^ (64'h1 << b));
    g = prbs(g);
  endtask

  task automatic gap();
    step(1, 0, {$urandom, $urandom});
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every clock the DUT presents a fresh output set.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (locked !== e.lk || samps !== CNT_W'(e.sm) || errors !== CNT_W'(e.er) ||
          lock_losses !== 16'(e.ll) || locked_s !== e.lk ||
          samps_s !== SAT_W'(cap(e.sm)) || errors_s !== SAT_W'(cap(e.er)) ||
          lock_losses_s !== 16'(e.ll)) begin
        miscompares++;
        $display("FAIL outputs @%0t: got lk=%0b sm=%0d er=%0d ll=%0d sat(lk=%0b sm=%0d er=%0d ll=%0d) expected lk=%0b sm=%0d er=%0d ll=%0d",
                 $time, locked, samps, errors, lock_losses, locked_s, samps_s, errors_s,
                 lock_losses_s, e.lk, e.sm, e.er, e.ll);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid, nafter, k;
    rst = 1'b1; en = 1'b0; i_tvalid = 1'b0; i_tdata = '0;
    model_reset();
    #1;
    check("reset_locked", locked, 0);
    check("reset_samps", samps, 0);
    check("reset_errors", errors, 0);
    check("reset_lock_losses", lock_losses, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Continuous PRBS seeded with 1
    g = 64'h1;
    step(1, 0, '0);
    repeat (8) good();
    settle(); check("no_lock_after_8", locked, 0);
    good();
    settle(); check("lock_after_9", locked, 1);
    repeat (512) good();
    settle();
    check("cont_samps_512", samps, 512);
    check("cont_errors_0", errors, 0);

    // Rate-limited stream: one valid word in four
    step(0, 0, '0); step(1, 0, '0);
    nvalid = 0; nafter = 0;
    repeat (150) begin
      repeat (3) gap();
      good();
      nvalid++;
      if (nvalid > LOCK_COUNT + 1) nafter++;
    end
    settle();
    check("rate_locked", locked, 1);
    check("rate_samps", samps, nafter);
    check("rate_errors", errors, 0);

    // Three isolated bit-17 errors while locked
    for (k = 0; k < 3; k++) begin
      bad(17);
      repeat (5) good();
    end
    settle();
    check("iso_errors", errors, 3);
    check("iso_locked", locked, 1);
    check("iso_samps", samps, nafter + 18);

    // Four consecutive wrong words drop lock, then re-lock
    step(0, 0, '0); step(1, 0, '0);
    repeat (LOCK_COUNT + 1) good();
    repeat (20) good();
    repeat (3) bad($urandom_range(63));
    settle(); check("burst3_locked", locked, 1);
    bad($urandom_range(63));
    settle();
    check("burst4_locked", locked, 0);
    check("burst4_losses", lock_losses, 1);
    check("burst4_errors", errors, 4);
    repeat (8) good();
    settle(); check("relock_after_8", locked, 0);
    good();
    settle(); check("relock_after_9", locked, 1);

    // Zeros in SEEK, then a corrupted word during ACQUIRE
    step(0, 0, '0); step(1, 0, '0);
    repeat (5) step(1, 1, '0);
    settle(); check("zeros_no_lock", locked, 0);
    repeat (4) good();
    bad(5);
    repeat (8) good();
    settle(); check("reseed_no_lock_8", locked, 0);
    good();
    settle(); check("reseed_lock_9", locked, 1);

    // en falls together with a valid word, then re-enable
    repeat (10) good();
    step(0, 1, g);
    settle(); check("dis_locked", locked, 0);
    repeat (5) step(0, 1, {$urandom, $urandom});
    step(1, 0, '0);
    settle();
    check("reen_samps", samps, 0);
    check("reen_errors", errors, 0);
    check("reen_losses", lock_losses, 0);

    // Randomised soak with gaps, errors, bursts and enable drops
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(999);
      if (r < 5) step(0, $urandom_range(1), {$urandom, $urandom});
      else if (r < 250) gap();
      else if (r < 255) repeat ($urandom_range(6, 4)) bad($urandom_range(63));
      else if (r < 285) bad($urandom_range(63));
      else if (r < 290) begin step(1, 1, '0); g = prbs(g); end
      else good();
    end

    // Asynchronous reset mid-stream
    repeat (20) good();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_locked", locked, 0);
    check("arst_samps", samps, 0);
    check("arst_errors", errors, 0);
    check("arst_losses", lock_losses, 0);
    check("arst_sat_samps", samps_s, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(1, 0, '0);
    repeat (LOCK_COUNT + 1 + 5) good();

    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
    #3;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
